// File: rtl/alu_dmem_gprs.sv
// Single-cycle datapath slice: 8-entry register file, ALU and small data memory.
// Define GPR_R0_ZERO_EN to hardwire register 0 to zero.
module alu_dmem_gprs #(
   parameter int unsigned DW    = 16,
   parameter int unsigned DM_AW = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [2:0]    rs1,
   input  logic [2:0]    rs2,
   input  logic [2:0]    wr_dest,
   input  logic          reg_write,
   input  logic [DW-1:0] ext_imm,
   input  logic          alu_src,
   input  logic [2:0]    alu_op,
   input  logic          mem_read,
   input  logic          mem_write,
   input  logic          mem_to_reg,
   output logic [DW-1:0] reg_read_data_1,
   output logic [DW-1:0] reg_read_data_2,
   output logic [DW-1:0] alu_out,
   output logic          zero,
   output logic [DW-1:0] mem_read_data,
   output logic [DW-1:0] wb_data
);

   localparam int unsigned DmWords = 2 ** DM_AW;

   logic [DW-1:0]    regs_q [8];
   logic [DW-1:0]    mem_q  [DmWords];
   logic [DW-1:0]    alu_b;
   logic [DM_AW-1:0] dm_addr;

   // Reads see pre-edge contents; writes land on the next edge (no bypass).
   always_comb begin
      reg_read_data_1 = regs_q[rs1];
      reg_read_data_2 = regs_q[rs2];
`ifdef GPR_R0_ZERO_EN
      if (rs1 == 3'd0) reg_read_data_1 = '0;
      if (rs2 == 3'd0) reg_read_data_2 = '0;
`endif
   end

   assign alu_b = alu_src ? ext_imm : reg_read_data_2;

   // Shift amounts >= DW yield 0 by the language's shift semantics.
   always_comb begin
      alu_out = '0;
      case (alu_op)
         3'b000:  alu_out = reg_read_data_1 + alu_b;
         3'b001:  alu_out = reg_read_data_1 - alu_b;
         3'b010:  alu_out = ~reg_read_data_1;
         3'b011:  alu_out = reg_read_data_1 << alu_b;
         3'b100:  alu_out = reg_read_data_1 >> alu_b;
         3'b101:  alu_out = reg_read_data_1 & alu_b;
         3'b110:  alu_out = reg_read_data_1 | alu_b;
         default: alu_out[0] = reg_read_data_1 < alu_b;
      endcase
   end

   assign zero          = (alu_out == '0);
   assign dm_addr       = alu_out[DM_AW-1:0];
   assign mem_read_data = mem_read ? mem_q[dm_addr] : '0;
   assign wb_data       = mem_to_reg ? mem_read_data : alu_out;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < 8; i++) regs_q[i] <= '0;
      end else if (reg_write) begin
`ifdef GPR_R0_ZERO_EN
         if (wr_dest != 3'd0) regs_q[wr_dest] <= wb_data;
`else
         regs_q[wr_dest] <= wb_data;
`endif
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < DmWords; i++) mem_q[i] <= '0;
      end else if (mem_write) begin
         mem_q[dm_addr] <= reg_read_data_2;
      end
   end

endmodule

// File: tb/tb_alu_dmem_gprs.sv
// Self-checking bench for alu_dmem_gprs: directed cases plus randomized traffic
// against an array-based reference model.
module tb_alu_dmem_gprs;

   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [2:0]    rs1 = '0, rs2 = '0, wr_dest = '0, alu_op = '0;
   logic          reg_write = 1'b0, alu_src = 1'b0;
   logic          mem_read = 1'b0, mem_write = 1'b0, mem_to_reg = 1'b0;
   logic [DW-1:0] ext_imm = '0;
   logic [DW-1:0] reg_read_data_1, reg_read_data_2, alu_out, mem_read_data, wb_data;
   logic          zero;

   int errors = 0;
   int checks = 0;
   bit run_cmp = 1'b0;

   logic [DW-1:0] m_regs [8];
   logic [DW-1:0] m_mem  [8];

   alu_dmem_gprs #(.DW(DW), .DM_AW(3)) dut (
      .clk(clk), .rst(rst), .rs1(rs1), .rs2(rs2), .wr_dest(wr_dest),
      .reg_write(reg_write), .ext_imm(ext_imm), .alu_src(alu_src), .alu_op(alu_op),
      .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
      .reg_read_data_1(reg_read_data_1), .reg_read_data_2(reg_read_data_2),
      .alu_out(alu_out), .zero(zero), .mem_read_data(mem_read_data), .wb_data(wb_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] m_read(input logic [2:0] idx);
`ifdef GPR_R0_ZERO_EN
      if (idx == 3'd0) return '0;
`endif
      return m_regs[idx];
   endfunction

   // Expected outputs from the current inputs and model state.
   function automatic void model_eval(output logic [DW-1:0] e_r1, output logic [DW-1:0] e_r2,
                                      output logic [DW-1:0] e_alu, output logic e_z,
                                      output logic [DW-1:0] e_mrd, output logic [DW-1:0] e_wb);
      int unsigned a, b, r;
      e_r1 = m_read(rs1);
      e_r2 = m_read(rs2);
      a = int'(e_r1);
      b = alu_src ? int'(ext_imm) : int'(e_r2);
      case (alu_op)
         3'd0: r = (a + b) % 65536;
         3'd1: r = (a + 65536 - b) % 65536;
         3'd2: r = 65535 - a;
         3'd3: r = (b >= 16) ? 0 : (a * (1 << b)) % 65536;
         3'd4: r = (b >= 16) ? 0 : a / (1 << b);
         3'd5: r = a & b;
         3'd6: r = a | b;
         default: r = (a < b) ? 1 : 0;
      endcase
      e_alu = r[DW-1:0];
      e_z   = (r == 0);
      e_mrd = mem_read ? m_mem[r % 8] : '0;
      e_wb  = mem_to_reg ? e_mrd : e_alu;
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < 8; i++) begin
         m_regs[i] = '0;
         m_mem[i]  = '0;
      end
   endfunction

   always @(negedge clk) begin
      logic [DW-1:0] e_r1, e_r2, e_alu, e_mrd, e_wb;
      logic e_z;
      if (run_cmp && !rst) begin
         model_eval(e_r1, e_r2, e_alu, e_z, e_mrd, e_wb);
         chk("rd1", 32'(reg_read_data_1), 32'(e_r1));
         chk("rd2", 32'(reg_read_data_2), 32'(e_r2));
         chk("alu_out", 32'(alu_out), 32'(e_alu));
         chk("zero", 32'(zero), 32'(e_z));
         chk("mem_read_data", 32'(mem_read_data), 32'(e_mrd));
         chk("wb_data", 32'(wb_data), 32'(e_wb));
      end
   end

   // Advance one edge, applying this cycle's writes to the model.
   task automatic tick();
      logic [DW-1:0] e_r1, e_r2, e_alu, e_mrd, e_wb;
      logic e_z;
      @(posedge clk);
      if (!rst) begin
         model_eval(e_r1, e_r2, e_alu, e_z, e_mrd, e_wb);
         if (mem_write) m_mem[e_alu[2:0]] = e_r2;
         if (reg_write) m_regs[wr_dest] = e_wb;
      end
      #1;
   endtask

   task automatic drive(input logic [2:0] a1, input logic [2:0] a2, input logic [2:0] wd,
                        input logic rw, input logic [DW-1:0] imm, input logic src,
                        input logic [2:0] op, input logic mr, input logic mw, input logic m2r);
      rs1 = a1; rs2 = a2; wr_dest = wd; reg_write = rw; ext_imm = imm; alu_src = src;
      alu_op = op; mem_read = mr; mem_write = mw; mem_to_reg = m2r;
   endtask

   initial begin
      logic [31:0] rnd;
      model_reset();
      tick();
      tick();
      rst = 1'b0;
      run_cmp = 1'b1;

      // Everything reads zero after reset.
      for (int i = 0; i < 8; i++) begin
         drive(3'(i), 3'(i), 3'd0, 1'b0, 16'(i), 1'b1, 3'd0, 1'b1, 1'b0, 1'b0);
         #1;
         chk("reset_reg", 32'(reg_read_data_1), 32'd0);
         chk("reset_mem", 32'(mem_read_data), 32'd0);
      end
      tick();

      // r1 = 5, r2 = 3 via immediate adds to r0.
      drive(3'd0, 3'd0, 3'd1, 1'b1, 16'd5, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0); tick();
      drive(3'd0, 3'd0, 3'd2, 1'b1, 16'd3, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0); tick();
      drive(3'd1, 3'd2, 3'd0, 1'b0, 16'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0); #1;
      chk("add_5_3", 32'(alu_out), 32'd8);
      chk("add_zero", 32'(zero), 32'd0);
      alu_op = 3'd1; #1;
      chk("sub_5_3", 32'(alu_out), 32'd2);
      chk("sub_zero", 32'(zero), 32'd0);
      alu_op = 3'd7; #1;
      chk("slt_5_3", 32'(alu_out), 32'd0);
      chk("slt_zero", 32'(zero), 32'd1);
      tick();

      // r1 = 3: 3-3 = 0; then r1 = 1: 1 << 16 = 0.
      drive(3'd0, 3'd0, 3'd1, 1'b1, 16'd3, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0); tick();
      drive(3'd1, 3'd2, 3'd0, 1'b0, 16'd0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0); #1;
      chk("sub_equal", 32'(alu_out), 32'd0);
      chk("sub_equal_zero", 32'(zero), 32'd1);
      tick();
      drive(3'd0, 3'd0, 3'd1, 1'b1, 16'd1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0); tick();
      drive(3'd1, 3'd2, 3'd0, 1'b0, 16'd16, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0); #1;
      chk("shl_16", 32'(alu_out), 32'd0);
      tick();

      // Store r2 = 0x1234 at address 9 (wraps to 1), load address 1 into r5.
      drive(3'd0, 3'd0, 3'd2, 1'b1, 16'h1234, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0); tick();
      drive(3'd0, 3'd2, 3'd0, 1'b0, 16'd9, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0); tick();
      drive(3'd0, 3'd0, 3'd5, 1'b1, 16'd1, 1'b1, 3'd0, 1'b1, 1'b0, 1'b1); #1;
      chk("load_wb", 32'(wb_data), 32'h1234);
      tick();
      drive(3'd5, 3'd0, 3'd0, 1'b0, 16'd1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1); #1;
      chk("load_reg", 32'(reg_read_data_1), 32'h1234);
      chk("no_read", 32'(mem_read_data), 32'd0);
      tick();

      // Same-cycle write/read of r4 returns old value until the edge.
      drive(3'd0, 3'd4, 3'd4, 1'b1, 16'h00AB, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0); #1;
      chk("r4_old", 32'(reg_read_data_2), 32'd0);
      tick();
      reg_write = 1'b0; #1;
      chk("r4_new", 32'(reg_read_data_2), 32'h00AB);

      // Asynchronous reset between edges; writes ignored while held.
      drive(3'd0, 3'd4, 3'd4, 1'b1, 16'd1, 1'b1, 3'd0, 1'b1, 1'b1, 1'b0);
      rst = 1'b1;
      model_reset();
      #1;
      chk("async_rst_reg", 32'(reg_read_data_2), 32'd0);
      chk("async_rst_mem", 32'(mem_read_data), 32'd0);
      ext_imm = 16'd0; #1;
      chk("rst_zero_flag", 32'(zero), 32'd1);
      tick();
      chk("rst_ignores_write", 32'(reg_read_data_2), 32'd0);
      rst = 1'b0;
      drive(3'd0, 3'd0, 3'd0, 1'b0, 16'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
      tick();

      // Register 0 write.
      drive(3'd0, 3'd0, 3'd0, 1'b1, 16'hFFFF, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0); tick();
      reg_write = 1'b0; #1;
`ifdef GPR_R0_ZERO_EN
      chk("r0_hardwired", 32'(reg_read_data_1), 32'd0);
`else
      chk("r0_plain", 32'(reg_read_data_1), 32'hFFFF);
`endif
      tick();

      // Randomized traffic checked by the negedge compare process.
      for (int n = 0; n < 400; n++) begin
         rnd = $urandom();
         rs1 = rnd[2:0]; rs2 = rnd[5:3]; wr_dest = rnd[8:6]; alu_op = rnd[11:9];
         reg_write = rnd[12]; alu_src = rnd[13]; mem_read = rnd[14];
         mem_write = rnd[15]; mem_to_reg = rnd[16];
         rnd = $urandom();
         ext_imm = rnd[31] ? 16'($urandom_range(0, 20)) : rnd[15:0];
         tick();
      end

      run_cmp = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
